// File: rtl/fetch_istruzione_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// instruction field positions and PC offsets.
package fetch_istruzione_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    localparam int PC_INCR    = 4;
    localparam int R15_OFFSET = 8;

endpackage

// File: rtl/fetch_istruzione_registro_pc.sv
// Program counter register with next-PC selection (sequential or branch
// target) and the PC+8 value read back as R15.
module registro_pc
    import fetch_istruzione_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              sel_target,
    input  logic [DATA_W-1:0] target,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus8
);

    logic [DATA_W-1:0] pc_next;

    // Both sums wrap naturally at the register width.
    assign pc_next  = sel_target ? target : pc + DATA_W'(PC_INCR);
    assign pc_plus8 = pc + DATA_W'(R15_OFFSET);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_istruzione.sv
// Instruction-fetch stage: fetches words from a variable-latency memory,
// holds them in the instruction register and issues them to the control unit.
module fetch_istruzione
    import fetch_istruzione_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              pcsrc,
    input  logic [DATA_W-1:0] result,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus8,
    output logic [DATA_W-1:0] instr_count,
    output logic              fault
);

    state_t state_q, state_d;
    logic   consume;
    logic   misaligned;
    logic   capture;

    assign consume    = (state_q == ST_ISSUE) && !stall;
    assign misaligned = pcsrc && (result[1:0] != 2'b00);
    assign capture    = (state_q == ST_FETCH) && imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
            ST_ISSUE: if (!stall) state_d = misaligned ? ST_FAULT : ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: decoded from state only, never from inputs.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_ISSUE);
    assign imem_addr   = pc;

    // A misaligned branch target leaves the PC on the faulting instruction.
    registro_pc #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_registro_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (consume && !misaligned),
        .sel_target (pcsrc),
        .target     (result),
        .pc         (pc),
        .pc_plus8   (pc_plus8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
        end else begin
            if (capture) instr <= imem_rdata;
            if (consume) instr_count <= instr_count + 1'b1;
            if (consume && misaligned) fault <= 1'b1;
        end
    end

    assign cond  = instr[COND_HI:COND_LO];
    assign op    = instr[OP_HI:OP_LO];
    assign funct = instr[FUNCT_HI:FUNCT_LO];
    assign rd    = instr[RD_HI:RD_LO];

endmodule
